// File: rtl/shift_unit.sv
// Registered RV32I/RV64I shift unit: SLL/SRL/SRA over a single log2(XLEN)-stage
// right barrel shifter; SLL bit-reverses the operand and result around it.
module shift_unit #(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            rst_n,
    input  logic [XLEN-1:0] Src1,
    input  logic [5:0]      Src2,
    input  logic            funct3_2,
    input  logic            funct7_5,
    input  logic            En,
    output logic [XLEN-1:0] Result
);

    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0]  shamt;
    logic            fill;
    logic [XLEN-1:0] src_rev;
    logic [XLEN-1:0] operand;
    logic [XLEN-1:0] stage [SHW+1];
    logic [XLEN-1:0] shifted_rev;
    logic [XLEN-1:0] result_next;
    logic            unused_src2;

    // On RV32 the top bit of Src2 is ignored; only the low log2(XLEN) bits count.
    assign shamt       = Src2[SHW-1:0];
    assign unused_src2 = ^Src2;

    // Only SRA replicates the sign bit; SRL and SLL shift in zeros.
    assign fill = funct7_5 & funct3_2 & Src1[XLEN-1];

    for (genvar i = 0; i < XLEN; i++) begin : g_rev
        assign src_rev[i]     = Src1[XLEN-1-i];
        assign shifted_rev[i] = stage[SHW][XLEN-1-i];
    end

    assign operand  = funct3_2 ? Src1 : src_rev;
    assign stage[0] = operand;

    for (genvar s = 0; s < SHW; s++) begin : g_stage
        localparam int D = 1 << s;
        assign stage[s+1] = shamt[s] ? {{D{fill}}, stage[s][XLEN-1:D]} : stage[s];
    end

    always_comb begin
        // NOTE: defaulting every always_comb output first means no path leaves it unassigned, so no latch.
        result_next = '0;
        if (En) begin
            unique case ({funct7_5, funct3_2})
                2'b00:   result_next = shifted_rev;
                2'b01,
                2'b11:   result_next = stage[SHW];
                default: result_next = '0;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        // NOTE: non-blocking assignment for registered state avoids simulation ordering races.
        if (!rst_n) begin
            Result <= '0;
        end else begin
            Result <= result_next;
        end
    end

endmodule

// File: tb/tb_shift_unit.sv
// Scoreboard bench for shift_unit: one XLEN=32 and one XLEN=64 instance share stimulus;
// the driver queues expected results, a negedge monitor pops and compares them.
module tb_shift_unit;

    logic        CLK = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] src1 = '0;
    logic [5:0]  src2 = '0;
    logic        funct3_2 = 1'b0;
    logic        funct7_5 = 1'b0;
    logic        en = 1'b0;
    logic [31:0] result32;
    logic [63:0] result64;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        string       name;
        logic [63:0] e32;
        logic [63:0] e64;
    } exp_t;

    exp_t exp_q[$];

    always #5 CLK = ~CLK;

    shift_unit #(.XLEN(32)) dut32 (
        .CLK(CLK), .rst_n(rst_n), .Src1(src1[31:0]), .Src2(src2),
        .funct3_2(funct3_2), .funct7_5(funct7_5), .En(en), .Result(result32)
    );

    shift_unit #(.XLEN(64)) dut64 (
        .CLK(CLK), .rst_n(rst_n), .Src1(src1), .Src2(src2),
        .funct3_2(funct3_2), .funct7_5(funct7_5), .En(en), .Result(result64)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    // Reference model built on the native shift operators.
    function automatic logic [63:0] model(input logic [63:0] a, input logic [5:0] b,
                                          input logic f7, input logic f3, input logic e,
                                          input bit is64);
        logic [31:0] a32;
        logic [31:0] r32;
        logic [4:0]  sh32;
        a32  = a[31:0];
        sh32 = b[4:0];
        if (!e) return '0;
        if (is64) begin
            case ({f7, f3})
                2'b00:   return a << b;
                2'b01:   return a >> b;
                2'b11:   return $signed(a) >>> b;
                default: return '0;
            endcase
        end
        case ({f7, f3})
            2'b00:   r32 = a32 << sh32;
            2'b01:   r32 = a32 >> sh32;
            2'b11:   r32 = $signed(a32) >>> sh32;
            default: r32 = '0;
        endcase
        return {32'b0, r32};
    endfunction

    task automatic issue(input string name, input logic [63:0] a, input logic [5:0] b,
                         input logic f7, input logic f3, input logic e,
                         input logic [63:0] e32, input logic [63:0] e64);
        exp_t x;
        @(negedge CLK);
        src1 = a; src2 = b; funct7_5 = f7; funct3_2 = f3; en = e;
        @(posedge CLK);
        x.name = name; x.e32 = e32; x.e64 = e64;
        exp_q.push_back(x);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge CLK);
        #1;
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    always @(negedge CLK) begin
        if (exp_q.size() != 0) begin
            exp_t x;
            x = exp_q.pop_front();
            check({x.name, "/x32"}, {32'b0, result32}, x.e32);
            check({x.name, "/x64"}, result64, x.e64);
        end
    end

    initial begin
        #2;
        check("reset32", {32'b0, result32}, 64'd0);
        check("reset64", result64, 64'd0);
        @(negedge CLK);
        rst_n = 1'b1;

        //    name        Src1                    Src2       f7 f3 en  exp32                   exp64
        issue("sll",      64'd50,                 6'd4,      0, 0, 1, 64'd800,               64'd800);
        issue("srl",      64'hABCDFFFF,           6'd5,      0, 1, 1, 64'h055E6FFF,          64'h055E6FFF);
        issue("sra",      64'hABCDFFFF,           6'd3,      1, 1, 1, 64'hF579BFFF,          64'h1579BFFF);
        issue("illegal",  64'h12345678,           6'd2,      1, 0, 1, 64'd0,                 64'd0);
        issue("src2_b5",  64'h80000000,           6'b100001, 0, 1, 1, 64'h40000000,          64'd0);
        issue("sll0",     64'hDEADBEEF,           6'd0,      0, 0, 1, 64'hDEADBEEF,          64'hDEADBEEF);
        issue("srl0",     64'hDEADBEEF,           6'd0,      0, 1, 1, 64'hDEADBEEF,          64'hDEADBEEF);
        issue("sra0",     64'hDEADBEEF,           6'd0,      1, 1, 1, 64'hDEADBEEF,          64'hDEADBEEF);
        issue("sra31",    64'h80000000,           6'd31,     1, 1, 1, 64'hFFFFFFFF,          64'd1);
        issue("srl31",    64'h80000000,           6'd31,     0, 1, 1, 64'd1,                 64'd1);
        issue("sll31",    64'h00000001,           6'd31,     0, 0, 1, 64'h80000000,          64'h80000000);
        issue("sra63",    64'h8000000000000000,   6'd63,     1, 1, 1, 64'd0,                 64'hFFFFFFFFFFFFFFFF);
        issue("srl63",    64'h8000000000000000,   6'd63,     0, 1, 1, 64'd0,                 64'd1);
        issue("sll63",    64'h1,                  6'd63,     0, 0, 1, 64'h80000000,          64'h8000000000000000);
        issue("sra_neg",  64'hFFFFFFFF80000000,   6'd4,      1, 1, 1, 64'hF8000000,          64'hFFFFFFFFF8000000);
        issue("en_off",   64'hDEADBEEFDEADBEEF,   6'd7,      1, 1, 0, 64'd0,                 64'd0);
        issue("op_swap",  64'hF0F0F0F0,           6'd8,      0, 0, 1, 64'hF0F0F000,          64'hF0F0F0F000);

        for (int i = 0; i < 1000; i++) begin
            logic [63:0] a;
            logic [5:0]  b;
            logic        f7, f3, e;
            a  = {$urandom, $urandom};
            b  = 6'($urandom_range(0, 63));
            f7 = 1'($urandom_range(0, 1));
            f3 = 1'($urandom_range(0, 1));
            e  = ($urandom_range(0, 7) != 0);
            issue("rand", a, b, f7, f3, e, model(a, b, f7, f3, e, 1'b0), model(a, b, f7, f3, e, 1'b1));
        end

        issue("pre_rst",  64'h00000000000000FF,   6'd4,      0, 0, 1, 64'h00000FF0,          64'h00000FF0);
        drain();

        // Mid-cycle async reset with live, enabled operands held on the inputs.
        @(posedge CLK);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async32", {32'b0, result32}, 64'd0);
        check("rst_async64", result64, 64'd0);
        @(posedge CLK);
        #1;
        check("rst_hold32", {32'b0, result32}, 64'd0);
        check("rst_hold64", result64, 64'd0);
        @(negedge CLK);
        en = 1'b0;
        rst_n = 1'b1;
        #1;
        check("rst_rel32", {32'b0, result32}, 64'd0);
        check("rst_rel64", result64, 64'd0);
        @(posedge CLK);
        #1;
        check("no_replay32", {32'b0, result32}, 64'd0);
        check("no_replay64", result64, 64'd0);

        issue("post_rst", 64'h0000000000000003,   6'd1,      0, 0, 1, 64'd6,                 64'd6);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
